// File: rtl/shot_pkg.sv
// Shared types and width helpers for the shot capture buffer.
package shot_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        READOUT   = 3'd4
    } state_t;

    // Pointer width for a ring of 'depth' entries.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Channel index width; a single channel still gets one bit.
    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/shot_capture_buffer_if.sv
// Capture-side inputs and readout stream of the shot capture buffer.
interface shot_capture_buffer_if
    import shot_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2
) ();
    localparam int CW = chan_w(CHANNELS);

    logic                      tick_i;
    logic [CHANNELS*WIDTH-1:0] signal_i;
    logic                      arm_i;
    logic                      trig_i;
    logic                      auto_i;
    logic                      rd_ready_i;
    logic                      rd_valid_o;
    logic [WIDTH-1:0]          rd_data_o;
    logic [CW-1:0]             rd_chan_o;
    logic                      rd_last_o;
    state_t                    state_o;
    logic                      busy_o;

    // Producer / consumer side (drives samples and control, takes the stream).
    modport master (
        output tick_i, signal_i, arm_i, trig_i, auto_i, rd_ready_i,
        input  rd_valid_o, rd_data_o, rd_chan_o, rd_last_o, state_o, busy_o
    );

    // Capture buffer side.
    modport slave (
        input  tick_i, signal_i, arm_i, trig_i, auto_i, rd_ready_i,
        output rd_valid_o, rd_data_o, rd_chan_o, rd_last_o, state_o, busy_o
    );

endinterface

// File: rtl/shot_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module shot_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Write port: one full row (all channels) per sample tick.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, held while rd_en is low.
    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/shot_capture_buffer.sv
// Circular multi-channel capture with pre-trigger history, streamed out
// sample-major / channel-minor over a valid/ready port.
module shot_capture_buffer
    import shot_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 1024,
    parameter int PRE_TRIG = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    shot_capture_buffer_if.slave bus
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = chan_w(CHANNELS);
    localparam int RW = CHANNELS * WIDTH;

    localparam logic [PW-1:0] PRE_PTR   = PW'(PRE_TRIG);
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_TRIG - 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]   POST_LEN  = (PW+1)'(DEPTH - PRE_TRIG);
    localparam logic [PW:0]   ROWS      = (PW+1)'(DEPTH);
    localparam logic [CW-1:0] CHAN_LAST = CW'(CHANNELS - 1);
    localparam logic [CW-1:0] CHAN_ONE  = CW'(1);

    state_t           state_reg,      state_next;
    logic [PW-1:0]    wr_ptr_reg,     wr_ptr_next;
    logic [PW-1:0]    fill_cnt_reg,   fill_cnt_next;
    logic [PW:0]      post_cnt_reg,   post_cnt_next;
    logic [PW-1:0]    start_addr_reg, start_addr_next;
    logic [PW:0]      rd_cnt_reg,     rd_cnt_next;
    logic             row_valid_reg,  row_valid_next;
    logic             row_last_reg,   row_last_next;
    logic [CW-1:0]    chan_idx_reg,   chan_idx_next;
    logic             out_valid_reg,  out_valid_next;
    logic [WIDTH-1:0] out_data_reg,   out_data_next;
    logic [CW-1:0]    out_chan_reg,   out_chan_next;
    logic             out_last_reg,   out_last_next;

    logic             wr_en, rd_en, load, row_done;
    logic [PW-1:0]    rd_addr;
    logic [RW-1:0]    ram_q;
    logic [WIDTH-1:0] row_lane [CHANNELS];

    shot_ram #(.DATA_W(RW), .DEPTH(DEPTH), .ADDR_W(PW)) u_ram (
        .clk_i   (clk_i),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (bus.signal_i),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Split the held RAM row into per-channel lanes for the output mux.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            assign row_lane[gi] = ram_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign rd_addr = start_addr_reg + rd_cnt_reg[PW-1:0];

    // Next-state, pointer and readout-pipeline logic.
    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        fill_cnt_next   = fill_cnt_reg;
        post_cnt_next   = post_cnt_reg;
        start_addr_next = start_addr_reg;
        rd_cnt_next     = rd_cnt_reg;
        row_valid_next  = row_valid_reg;
        row_last_next   = row_last_reg;
        chan_idx_next   = chan_idx_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_chan_next   = out_chan_reg;
        out_last_next   = out_last_reg;
        wr_en           = 1'b0;
        rd_en           = 1'b0;
        // The output register takes the next channel of the held row
        // whenever it is empty or its word leaves this cycle.
        load     = row_valid_reg && (!out_valid_reg || bus.rd_ready_i);
        row_done = load && (chan_idx_reg == CHAN_LAST);

        case (state_reg)
            IDLE: begin
                if (bus.arm_i) begin
                    state_next    = PRE;
                    wr_ptr_next   = '0;
                    fill_cnt_next = '0;
                end
            end
            PRE: begin
                wr_en = bus.tick_i;
                if (PRE_TRIG == 0) begin
                    state_next = WAIT_TRIG;
                end else if (bus.tick_i) begin
                    fill_cnt_next = fill_cnt_reg + PTR_ONE;
                    if (fill_cnt_reg == PRE_LAST) begin
                        state_next = WAIT_TRIG;
                    end
                end
            end
            WAIT_TRIG: begin
                wr_en = bus.tick_i;
                if (bus.trig_i) begin
                    // Pointer before this cycle's increment, so a coincident
                    // tick becomes the first post-trigger sample.
                    start_addr_next = wr_ptr_reg - PRE_PTR;
                    post_cnt_next   = POST_LEN;
                    state_next      = POST;
                    if (bus.tick_i) begin
                        post_cnt_next = POST_LEN - CNT_ONE;
                        if (POST_LEN == CNT_ONE) begin
                            state_next = READOUT;
                        end
                    end
                end
            end
            POST: begin
                wr_en = bus.tick_i;
                if (bus.tick_i) begin
                    post_cnt_next = post_cnt_reg - CNT_ONE;
                    if (post_cnt_reg == CNT_ONE) begin
                        state_next = READOUT;
                    end
                end
            end
            READOUT: begin
                // Fetch the next row as soon as the held one is used up, so the
                // new row lands in the same edge its predecessor's last channel leaves.
                rd_en = (rd_cnt_reg != ROWS) && (!row_valid_reg || row_done);
                if (rd_en) begin
                    rd_cnt_next    = rd_cnt_reg + CNT_ONE;
                    row_valid_next = 1'b1;
                    row_last_next  = (rd_cnt_reg == ROWS - CNT_ONE);
                end else if (row_done) begin
                    row_valid_next = 1'b0;
                end
                if (load) begin
                    chan_idx_next  = row_done ? '0 : chan_idx_reg + CHAN_ONE;
                    out_valid_next = 1'b1;
                    out_data_next  = row_lane[chan_idx_reg];
                    out_chan_next  = chan_idx_reg;
                    out_last_next  = row_last_reg && (chan_idx_reg == CHAN_LAST);
                end else if (bus.rd_ready_i) begin
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                end
                if (out_valid_reg && bus.rd_ready_i && out_last_reg) begin
                    state_next    = bus.auto_i ? PRE : IDLE;
                    wr_ptr_next   = '0;
                    fill_cnt_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end

        // Outside readout the stream pipeline is always empty.
        if (state_reg != READOUT) begin
            rd_cnt_next    = '0;
            row_valid_next = 1'b0;
            chan_idx_next  = '0;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
        end
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            fill_cnt_reg   <= '0;
            post_cnt_reg   <= '0;
            start_addr_reg <= '0;
            rd_cnt_reg     <= '0;
            row_valid_reg  <= 1'b0;
            row_last_reg   <= 1'b0;
            chan_idx_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_chan_reg   <= '0;
            out_last_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            fill_cnt_reg   <= fill_cnt_next;
            post_cnt_reg   <= post_cnt_next;
            start_addr_reg <= start_addr_next;
            rd_cnt_reg     <= rd_cnt_next;
            row_valid_reg  <= row_valid_next;
            row_last_reg   <= row_last_next;
            chan_idx_reg   <= chan_idx_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_chan_reg   <= out_chan_next;
            out_last_reg   <= out_last_next;
        end
    end

    assign bus.rd_valid_o = out_valid_reg;
    assign bus.rd_data_o  = out_data_reg;
    assign bus.rd_chan_o  = out_chan_reg;
    assign bus.rd_last_o  = out_last_reg;
    assign bus.state_o    = state_reg;
    assign bus.busy_o     = (state_reg != IDLE);

endmodule

// File: tb/tb_shot_capture_buffer.sv
// Directed bench for shot_capture_buffer: ramp stimulus, scoreboard of
// expected readout words, stall-stability checks on the output port.
`timescale 1ns/1ps
module tb_shot_capture_buffer;
    import shot_pkg::*;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 16;
    localparam int PRE_TRIG = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        chan;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shot_capture_buffer_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    shot_capture_buffer #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   words_seen = 0;
    int   n          = 0;
    bit   tick_en    = 1'b0;
    int   trig_n     = -1;
    int   solo_n     = -1;

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_chan;
    logic        prev_last;
    exp_t        mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ramp source: tick every 5 clocks, ch0 = n, ch1 = -n; optional
    // coincident trigger at tick n == trig_n, or a lone trigger between
    // ticks just after tick solo_n.
    initial begin
        int          phase;
        logic [15:0] s0;
        phase        = 0;
        bus.tick_i   = 1'b0;
        bus.trig_i   = 1'b0;
        bus.signal_i = '0;
        forever begin
            @(posedge clk); #1;
            bus.tick_i = 1'b0;
            bus.trig_i = 1'b0;
            if (!tick_en) begin
                n     = 0;
                phase = 0;
            end else if (phase == 4) begin
                phase        = 0;
                s0           = n[15:0];
                bus.tick_i   = 1'b1;
                bus.signal_i = {16'(16'd0 - s0), s0};
                bus.trig_i   = (n == trig_n);
                n++;
            end else begin
                phase++;
                if (solo_n >= 0 && n == solo_n + 1 && phase == 2) begin
                    bus.trig_i = 1'b1;
                end
            end
        end
    end

    // Output monitor: pop and compare each transferred word; a stalled
    // word must be held unchanged on the next cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.rd_valid_o), 32'd1);
                check("stall_data", 32'(bus.rd_data_o), 32'(prev_data));
                check("stall_chan", 32'(bus.rd_chan_o), 32'(prev_chan));
                check("stall_last", 32'(bus.rd_last_o), 32'(prev_last));
            end
            if (bus.rd_valid_o && bus.rd_ready_i) begin
                check("word_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rd_data", 32'(bus.rd_data_o), 32'(mon_e.data));
                    check("rd_chan", 32'(bus.rd_chan_o), 32'(mon_e.chan));
                    check("rd_last", 32'(bus.rd_last_o), 32'(mon_e.last));
                    $display("word %0d: data=0x%04h chan=%0d last=%0d", words_seen,
                             bus.rd_data_o, bus.rd_chan_o, bus.rd_last_o);
                    words_seen++;
                end
            end
            prev_stall = bus.rd_valid_o && !bus.rd_ready_i;
            prev_data  = bus.rd_data_o;
            prev_chan  = bus.rd_chan_o;
            prev_last  = bus.rd_last_o;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic push_shot(input int first);
        for (int s = first; s < first + DEPTH; s++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                exp_t        e;
                logic [15:0] v;
                v      = 16'(s);
                e.data = (c == 0) ? v : 16'(16'd0 - v);
                e.chan = c[0];
                e.last = (s == first + DEPTH - 1) && (c == CHANNELS - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_shot(input int trig_at, input int first);
        tick_en = 1'b0;
        trig_n  = -1;
        cyc(2);
        bus.arm_i = 1'b1;
        cyc(1);
        bus.arm_i = 1'b0;
        trig_n    = trig_at;
        push_shot(first);
        tick_en   = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int budget, input bit bp);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            cyc(1);
            if (bp) bus.rd_ready_i = 1'($urandom_range(0, 1));
            k++;
        end
        bus.rd_ready_i = 1'b1;
        check(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_state(input string tag, input state_t target, input int budget);
        int k;
        k = 0;
        while (bus.state_o != target && k < budget) begin
            cyc(1);
            k++;
        end
        check(tag, 32'(bus.state_o), 32'(target));
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_state"}, 32'(bus.state_o), 32'(IDLE));
        check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_valid"}, 32'(bus.rd_valid_o), 32'd0);
    endtask

    initial begin
        int base;
        int k;
        bus.arm_i      = 1'b0;
        bus.auto_i     = 1'b0;
        bus.rd_ready_i = 1'b1;

        // Reset state
        cyc(3);
        @(negedge clk);
        check("rst_state", 32'(bus.state_o), 32'(IDLE));
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_valid", 32'(bus.rd_valid_o), 32'd0);
        check("rst_last", 32'(bus.rd_last_o), 32'd0);
        check("rst_data", 32'(bus.rd_data_o), 32'd0);
        check("rst_chan", 32'(bus.rd_chan_o), 32'd0);
        cyc(1);
        rst = 1'b0;

        // Basic shot: trigger with tick n=10 -> ch0 6..21
        start_shot(10, 6);
        wait_drain("drain_basic", 2000, 1'b0);
        check_idle("basic_end");

        // Early trigger in PRE is ignored; real trigger at n=20 -> 16..31
        solo_n = 2;
        start_shot(20, 16);
        k = 0;
        while (n < 3 && k < 200) begin
            cyc(1);
            k++;
        end
        cyc(3);
        @(negedge clk);
        check("early_trig_state", 32'(bus.state_o), 32'(PRE));
        solo_n = -1;
        wait_drain("drain_early", 2000, 1'b0);
        check_idle("early_end");

        // Random backpressure on the same shot as the basic case
        start_shot(10, 6);
        wait_drain("drain_backpressure", 3000, 1'b1);
        check_idle("bp_end");

        // Auto re-arm with wrapped start address, then a second shot
        bus.auto_i = 1'b1;
        start_shot(37, 33);
        wait_drain("drain_wrap", 3000, 1'b0);
        @(negedge clk);
        check("auto_rearm_state", 32'(bus.state_o), 32'(PRE));
        cyc(1);
        bus.auto_i = 1'b0;
        trig_n     = 70;
        push_shot(66);
        wait_drain("drain_second", 3000, 1'b0);
        check_idle("auto_end");

        // Reset after 7 words have transferred
        start_shot(10, 6);
        base = words_seen;
        k    = 0;
        while (words_seen - base < 7 && k < 2000) begin
            cyc(1);
            k++;
        end
        check("words_before_reset", 32'(words_seen - base), 32'd7);
        rst            = 1'b1;
        bus.rd_ready_i = 1'b0;
        tick_en        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_valid", 32'(bus.rd_valid_o), 32'd0);
        check("reset_mid_state", 32'(bus.state_o), 32'(IDLE));
        check("reset_mid_last", 32'(bus.rd_last_o), 32'd0);
        sb.delete();
        cyc(1);
        rst            = 1'b0;
        bus.rd_ready_i = 1'b1;
        cyc(10);
        check_idle("after_reset");
        start_shot(10, 6);
        wait_drain("drain_after_reset", 2000, 1'b0);
        check_idle("fresh_end");

        // Ticks arriving while READOUT is stalled must not touch the shot
        bus.rd_ready_i = 1'b0;
        start_shot(10, 6);
        wait_state("reach_readout", READOUT, 2000);
        cyc(100);
        check("stalled_state", 32'(bus.state_o), 32'(READOUT));
        bus.rd_ready_i = 1'b1;
        wait_drain("drain_stalled", 2000, 1'b0);
        check_idle("stalled_end");

        tick_en = 1'b0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
